// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
//
// Multi-read-port integer register file with a busy scoreboard. Decode reads
// NUM_RD operands and their busy flags and marks a destination busy on issue.
// Writeback writes the result and clears the busy flag. Register 0 always
// reads as zero and is never busy.
//
// Optional feature (compile-time macro RF_WB_BYPASS_EN):
//   defined     -> write-through forwarding. A read port addressing the
//                  register being written this cycle sees wdata and the
//                  post-writeback busy state in the same cycle.
//   not defined -> read ports reflect registered state only.
//
// Ports
//   clk          in   1               clock, rising edge
//   reset        in   1               synchronous, active-high reset
//   rd_addr      in   NUM_RD*AW       read addresses, port i = [i*AW +: AW]
//   rd_data      out  NUM_RD*DATA_W   read data, port i = [i*DATA_W +: DATA_W]
//   rd_busy      out  NUM_RD          pending-writer flag per read port
//   reg_write    in   1               writeback strobe
//   waddr        in   AW              writeback address
//   wdata        in   DATA_W          writeback data
//   issue_valid  in   1               decode issues an instruction with a dest
//   issue_rd     in   AW              destination to mark busy
//   flush        in   1               clear all busy flags (data unaffected)
// ----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     reg_write,
    input  logic [AW-1:0]            waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    input  logic                     flush
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                wr_en;

    // Writes to register 0 are dropped so its storage never leaves zero.
    assign wr_en = reg_write && (waddr != '0);

    // Scoreboard next state. Issue has priority over flush and writeback:
    // a same-cycle writeback belongs to the previous producer, while the
    // newly issued instruction still has to be tracked.
    always_comb begin
        busy_next = busy;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue_valid && (issue_rd == AW'(r))) begin
                busy_next[r] = 1'b1;
            end else if (flush) begin
                busy_next[r] = 1'b0;
            end else if (reg_write && (waddr == AW'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_en) begin
                regs[waddr] <= wdata;
            end
            busy <= busy_next;
        end
    end

    // Independent combinational read ports; any number may alias.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
`ifdef RF_WB_BYPASS_EN
            // Forward the writeback. The register stays busy only if the
            // same register is re-issued in this cycle.
            if (wr_en && (addr == waddr)) begin
                data = wdata;
                bsy  = issue_valid && (issue_rd == waddr);
            end
`endif
            if (addr == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
        assign rd_busy[i]                  = bsy;
    end

endmodule
